// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing control: load-use and branch-operand stalls, branch/jump flushes.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_seq_ctrl #(
   parameter int BR_STALLS = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_use_haz,
   input  logic             branch_haz,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

   localparam logic [2:0] BR_LOAD = 3'(BR_STALLS - 1);

   state_t     state, state_nx;
   logic [2:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      state_nx     = state;
      cnt_nx       = cnt;
      if (reset) begin
         state_nx = RUN;
         cnt_nx   = 3'd0;
      end else if (branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_nx     = FLUSH;
         cnt_nx       = 3'd0;
      end else begin
         case (state)
            FLUSH: begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               state_nx     = RUN;
            end
            STALL: begin
               if (jump) begin
                  if_id_flush = 1'b1;
                  state_nx    = RUN;
                  cnt_nx      = 3'd0;
               end else begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  // cnt counts the STALL cycles still owed including this one
                  cnt_nx       = (cnt != 3'd0) ? cnt - 3'd1 : 3'd0;
                  state_nx     = (cnt <= 3'd1) ? RUN : STALL;
               end
            end
            default: begin
               if (jump) begin
                  if_id_flush = 1'b1;
                  cnt_nx      = 3'd0;
                  state_nx    = RUN;
               end else if (branch_haz) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  cnt_nx       = BR_LOAD;
                  state_nx     = (BR_STALLS > 1) ? STALL : RUN;
               end else if (load_use_haz) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end
            end
         endcase
      end
   end

   assign state_o = state;

`ifdef PIPE_PERF_CNT_EN
   logic flush_evt;
   // a flush event starts on any taken branch, or a jump outside FLUSH
   assign flush_evt = !reset && (branch_taken || (jump && state != FLUSH));

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (!pc_write && stall_count != '1) stall_count <= stall_count + 1'b1;
         if (flush_evt && flush_count != '1) flush_count <= flush_count + 1'b1;
      end
   end
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Randomized + directed bench for pipe_seq_ctrl; two instances (BR_STALLS=2/CNT_W=16, BR_STALLS=3/CNT_W=4)
// are checked against a behavioural model of remaining-stall and pending-flush bookkeeping.
module tb_pipe_seq_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1, lu = 1'b0, bh = 1'b0, bt = 1'b0, jp = 1'b0;
   always #5 clk = ~clk;

   logic        pw0, iw0, bb0, fl0, pw1, iw1, bb1, fl1;
   logic [1:0]  st0, st1;
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;

   pipe_seq_ctrl #(.BR_STALLS(2), .CNT_W(16)) u_dut0 (
      .clk(clk), .reset(reset), .load_use_haz(lu), .branch_haz(bh), .branch_taken(bt), .jump(jp),
      .pc_write(pw0), .if_id_write(iw0), .id_ex_bubble(bb0), .if_id_flush(fl0), .state_o(st0),
      .stall_count(sc0), .flush_count(fc0));

   pipe_seq_ctrl #(.BR_STALLS(3), .CNT_W(4)) u_dut1 (
      .clk(clk), .reset(reset), .load_use_haz(lu), .branch_haz(bh), .branch_taken(bt), .jump(jp),
      .pc_write(pw1), .if_id_write(iw1), .id_ex_bubble(bb1), .if_id_flush(fl1), .state_o(st1),
      .stall_count(sc1), .flush_count(fc1));

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int br[2]   = '{2, 3};
   int cmax[2] = '{65535, 15};
   int stall_rem[2] = '{0, 0};   // forced stall cycles still owed after this one
   bit flush_tail[2] = '{0, 0};  // second flush cycle pending
   int scm[2] = '{0, 0}, fcm[2] = '{0, 0};

   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s[dut%0d] cyc %0d: got %0d expected %0d", tag, k, cyc, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit l, input bit b, input bit t, input bit j);
      reset = r; lu = l; bh = b; bt = t; jp = j;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         bit e_pw, e_iw, e_bb, e_fl, fev;
         int e_st;
         logic [31:0] g_pw, g_iw, g_bb, g_fl, g_st, g_sc, g_fc;
         e_pw = 1; e_iw = 1; e_bb = 0; e_fl = 0; fev = 0;
         e_st = flush_tail[k] ? 2 : (stall_rem[k] > 0 ? 1 : 0);
         if (r) ;
         else if (t) begin e_fl = 1; e_bb = 1; fev = 1; end
         else if (flush_tail[k]) begin e_fl = 1; e_bb = 1; end
         else if (j) begin e_fl = 1; fev = 1; end
         else if (stall_rem[k] > 0 || b || l) begin e_pw = 0; e_iw = 0; e_bb = 1; end
         if (k == 0) begin
            g_pw = 32'(pw0); g_iw = 32'(iw0); g_bb = 32'(bb0); g_fl = 32'(fl0);
            g_st = 32'(st0); g_sc = 32'(sc0); g_fc = 32'(fc0);
         end else begin
            g_pw = 32'(pw1); g_iw = 32'(iw1); g_bb = 32'(bb1); g_fl = 32'(fl1);
            g_st = 32'(st1); g_sc = 32'(sc1); g_fc = 32'(fc1);
         end
         chk("pc_write", k, g_pw, 32'(e_pw));
         chk("if_id_write", k, g_iw, 32'(e_iw));
         chk("id_ex_bubble", k, g_bb, 32'(e_bb));
         chk("if_id_flush", k, g_fl, 32'(e_fl));
         chk("state_o", k, g_st, 32'(e_st));
`ifdef PIPE_PERF_CNT_EN
         chk("stall_count", k, g_sc, 32'(scm[k]));
         chk("flush_count", k, g_fc, 32'(fcm[k]));
`else
         chk("stall_count", k, g_sc, 32'd0);
         chk("flush_count", k, g_fc, 32'd0);
`endif
         // advance model to the state after this clock edge
         if (r) begin
            stall_rem[k] = 0; flush_tail[k] = 0; scm[k] = 0; fcm[k] = 0;
         end else begin
            if (!e_pw && scm[k] < cmax[k]) scm[k]++;
            if (fev && fcm[k] < cmax[k]) fcm[k]++;
            if (t) begin stall_rem[k] = 0; flush_tail[k] = 1; end
            else if (flush_tail[k]) flush_tail[k] = 0;
            else if (j) stall_rem[k] = 0;
            else if (stall_rem[k] > 0) stall_rem[k]--;
            else if (b) stall_rem[k] = br[k] - 1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      // reset, idle, single load-use stall
      step(1,0,0,0,0); step(1,0,0,0,0);
      step(0,0,0,0,0); step(0,0,0,0,0);
      step(0,1,0,0,0); step(0,0,0,0,0); step(0,0,0,0,0);
      // branch operand hazard
      step(0,0,1,0,0); repeat (4) step(0,0,0,0,0);
      // taken branch in the second stall cycle
      step(0,0,1,0,0); step(0,0,0,1,0); repeat (3) step(0,0,0,0,0);
      // flush beats load-use; lone jump
      step(0,1,0,1,0); step(0,0,0,0,0); step(0,0,0,0,0);
      step(0,0,0,0,1); step(0,0,0,0,0); step(0,0,0,0,0);
      // reset during first STALL cycle
      step(0,0,1,0,0); step(1,0,0,0,0); step(0,0,0,0,0); step(0,0,0,0,0);
      // counter saturation on the narrow instance
      repeat (20) step(0,1,0,0,0);
      step(0,0,0,0,0);
      // random traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0,49) == 0, $urandom_range(0,3) == 0, $urandom_range(0,5) == 0,
              $urandom_range(0,9) == 0, $urandom_range(0,11) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
